// File: rtl/isa_pkg.sv
// ISA opcodes and sequencer state encoding
// shared by program_sequencer and its label table
package isa_pkg;

  localparam logic [3:0] OP_LDR = 4'b0101;
  localparam logic [3:0] OP_STL = 4'b0111;
  localparam logic [3:0] OP_BLT = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1110;

  typedef enum logic [2:0] {
    IDLE,
    LABEL_SCAN,
    RUN,
    LD_STALL,
    BR_FLUSH,
    DONE
  } seq_state_t;

endpackage

// File: rtl/label_table.sv
// Label table: 2**LBL_W entries of PC_W bits plus valid bits.
// Ports: i_clear_all (sync valid clear), i_we/i_waddr/i_wdata write, i_raddr -> o_rdata/o_rvalid async read.
module label_table #(
  parameter int PC_W  = 8,
  parameter int LBL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear_all,
  input  logic             i_we,
  input  logic [LBL_W-1:0] i_waddr,
  input  logic [PC_W-1:0]  i_wdata,
  input  logic [LBL_W-1:0] i_raddr,
  output logic [PC_W-1:0]  o_rdata,
  output logic             o_rvalid
);

  localparam int DEPTH = 2**LBL_W;

  logic [PC_W-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else if (i_clear_all) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_data[i_waddr]  <= i_wdata;
      r_valid[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata  = r_data[i_raddr];
  assign o_rvalid = r_valid[i_raddr];

endmodule

// File: rtl/program_sequencer.sv
// Two-pass fetch/PC controller: label scan pass, then run pass.
// Ports: start, instr, cmp_lt, mem_busy in; pc, label_pass, stall, flush, halted, err out.
module program_sequencer
  import isa_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int LBL_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      instr,
  input  logic            cmp_lt,
  input  logic            mem_busy,
  output logic [PC_W-1:0] pc,
  output logic            label_pass,
  output logic            stall,
  output logic            flush,
  output logic            halted,
  output logic            err
);

  seq_state_t       r_state, w_state;
  logic [PC_W-1:0]  r_pc, w_pc;
  logic             r_halted, w_halted;
  logic             r_err, w_err;
  logic             w_we, w_clr;
  logic [3:0]       w_op;
  logic [LBL_W-1:0] w_id;
  logic [PC_W-1:0]  w_tgt;
  logic             w_tvld;

  assign w_op = instr[7:4];
  assign w_id = instr[LBL_W-1:0];

  label_table #(
    .PC_W (PC_W),
    .LBL_W(LBL_W)
  ) u_tbl (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear_all(w_clr),
    .i_we       (w_we),
    .i_waddr    (w_id),
    .i_wdata    (r_pc),
    .i_raddr    (w_id),
    .o_rdata    (w_tgt),
    .o_rvalid   (w_tvld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_halted <= w_halted;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_halted = r_halted;
    w_err    = r_err;
    w_we     = 1'b0;
    w_clr    = 1'b0;
    // mem_busy freezes everything, start included
    if (!mem_busy) begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_state  = LABEL_SCAN;
            w_pc     = '0;
            w_clr    = 1'b1;
            w_err    = 1'b0;
            w_halted = 1'b0;
          end
        end
        LABEL_SCAN: begin
          if (w_op == OP_HLT) begin
            w_pc    = '0;
            w_state = RUN;
          end else begin
            w_we = (w_op == OP_STL);
            // last address reached with no HLT seen
            if (r_pc == {PC_W{1'b1}}) begin
              w_err   = 1'b1;
              w_state = DONE;
            end else begin
              w_pc = r_pc + 1'b1;
            end
          end
        end
        RUN: begin
          w_pc = r_pc + 1'b1;
          unique case (1'b1)
            (w_op == OP_LDR): w_state = LD_STALL;
            (w_op == OP_BLT): begin
              if (cmp_lt && w_tvld) begin
                w_pc    = w_tgt;
                w_state = BR_FLUSH;
              end else if (cmp_lt) begin
                w_pc    = r_pc;
                w_err   = 1'b1;
                w_state = DONE;
              end
            end
            (w_op == OP_HLT): begin
              w_pc     = r_pc;
              w_halted = 1'b1;
              w_state  = DONE;
            end
            default: ;
          endcase
        end
        LD_STALL: w_state = RUN;
        BR_FLUSH: begin
          w_pc    = r_pc + 1'b1;
          w_state = RUN;
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign pc         = r_pc;
  assign label_pass = (r_state == LABEL_SCAN);
  assign flush      = (r_state == BR_FLUSH);
  assign halted     = r_halted;
  assign err        = r_err;
  assign stall      = (r_state == LD_STALL) | mem_busy;

endmodule
